// File: rtl/complex_alu_pipe_pkg.sv
// Shared parameters for the complex ALU pipeline: default width, opcode encodings and latency.
package complex_alu_pipe_pkg;

  localparam int unsigned DataWidth   = 16;
  localparam int unsigned PipeLatency = 4;

  typedef enum logic [2:0] {
    OpPass   = 3'b000,
    OpCmul   = 3'b100,
    OpMulAdd = 3'b101,
    OpMulSub = 3'b110,
    OpCmac   = 3'b111
  } op_e;

  function automatic logic is_valid_op(input logic [2:0] op);
    return (op == OpPass) || op[2];
  endfunction

endpackage

// File: rtl/complex_alu_pipe_if.sv
// Sample/result bus of the complex ALU pipeline; master drives samples, slave is the ALU.
interface complex_alu_pipe_if #(
  parameter int unsigned DATA_WIDTH = 16
);
  logic                    in_valid;
  logic [2:0]              opcode;
  logic                    acc_first;
  logic                    acc_last;
  logic [2*DATA_WIDTH-1:0] din_1;
  logic [2*DATA_WIDTH-1:0] din_2;
  logic [2*DATA_WIDTH-1:0] din_3;
  logic                    sat_clr;
  logic                    out_valid;
  logic [2*DATA_WIDTH-1:0] dout;
  logic                    sat;
  logic                    sat_sticky;

  modport master (
    output in_valid, opcode, acc_first, acc_last, din_1, din_2, din_3, sat_clr,
    input  out_valid, dout, sat, sat_sticky
  );

  modport slave (
    input  in_valid, opcode, acc_first, acc_last, din_1, din_2, din_3, sat_clr,
    output out_valid, dout, sat, sat_sticky
  );
endinterface

// File: rtl/cplx_round_sat.sv
// Rounds one component (add half LSB, arithmetic shift by SHIFT) and saturates to DATA_WIDTH.
module cplx_round_sat #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned SHIFT      = 15,
  parameter int unsigned ACC_WIDTH  = 37
) (
  input  logic signed [ACC_WIDTH-1:0]  val,
  output logic signed [DATA_WIDTH-1:0] res,
  output logic                         clip
);
  // One extra bit so the rounding add cannot wrap at the accumulator extremes.
  localparam int unsigned SW = ACC_WIDTH + 1;
  localparam logic signed [SW-1:0] Half = (SHIFT == 0) ? '0 : (SW'(1) << (SHIFT - 1));
  localparam logic signed [SW-1:0] MaxV = (SW'(1) << (DATA_WIDTH - 1)) - SW'(1);
  localparam logic signed [SW-1:0] MinV = -(SW'(1) << (DATA_WIDTH - 1));

  logic signed [SW-1:0] rnd, shr;

  always_comb begin
    rnd  = SW'(val) + Half;
    shr  = rnd >>> SHIFT;
    clip = 1'b0;
    res  = shr[DATA_WIDTH-1:0];
    if (shr > MaxV) begin
      clip = 1'b1;
      res  = MaxV[DATA_WIDTH-1:0];
    end else if (shr < MinV) begin
      clip = 1'b1;
      res  = MinV[DATA_WIDTH-1:0];
    end
  end
endmodule

// File: rtl/complex_alu_pipe.sv
// Four-stage complex multiply / multiply-add / MAC pipeline with rounding and saturation.
module complex_alu_pipe
  import complex_alu_pipe_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DataWidth,
  parameter int unsigned SHIFT      = DATA_WIDTH - 1,
  parameter int unsigned ACC_GUARD  = 4
) (
  input logic               clk,
  input logic               rst,
  complex_alu_pipe_if.slave bus
);
  localparam int unsigned W    = DATA_WIDTH;
  localparam int unsigned DW   = 2 * W;
  localparam int unsigned AccW = 2 * W + 1 + ACC_GUARD;

  logic          s1_valid, s1_first, s1_last;
  op_e           s1_op;
  logic [DW-1:0] s1_x, s1_y, s1_z;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_op    <= OpPass;
      s1_x     <= '0;
      s1_y     <= '0;
      s1_z     <= '0;
    end else begin
      s1_valid <= bus.in_valid && is_valid_op(bus.opcode);
      s1_first <= bus.acc_first;
      s1_last  <= bus.acc_last;
      s1_op    <= op_e'(bus.opcode);
      s1_x     <= bus.din_1;
      s1_y     <= bus.din_2;
      s1_z     <= bus.din_3;
    end
  end

  logic signed [W-1:0]  xi, xq, yi, yq;
  logic signed [DW-1:0] p_ii, p_qq, p_qi, p_iq;
  logic                 s2_valid, s2_first, s2_last;
  op_e                  s2_op;
  logic [DW-1:0]        s2_base;

  assign xi = s1_x[DW-1:W];
  assign xq = s1_x[W-1:0];
  assign yi = s1_y[DW-1:W];
  assign yq = s1_y[W-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_valid <= 1'b0;
      s2_first <= 1'b0;
      s2_last  <= 1'b0;
      s2_op    <= OpPass;
      s2_base  <= '0;
      p_ii     <= '0;
      p_qq     <= '0;
      p_qi     <= '0;
      p_iq     <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_first <= s1_first;
      s2_last  <= s1_last;
      s2_op    <= s1_op;
      // PASS reuses the addend path, so x rides along in place of z.
      s2_base  <= (s1_op == OpPass) ? s1_x : s1_z;
      p_ii     <= xi * yi;
      p_qq     <= xq * yq;
      p_qi     <= xq * yi;
      p_iq     <= xi * yq;
    end
  end

  logic signed [AccW-1:0] prod_i, prod_q, base_i, base_q;
  logic signed [AccW-1:0] acc_i_d, acc_q_d, acc_i_q, acc_q_q;
  logic signed [AccW-1:0] comb_i, comb_q, s3_i, s3_q;
  logic                   s3_valid;

  always_comb begin
    prod_i  = AccW'(p_ii) - AccW'(p_qq);
    prod_q  = AccW'(p_qi) + AccW'(p_iq);
    base_i  = AccW'($signed(s2_base[DW-1:W])) <<< SHIFT;
    base_q  = AccW'($signed(s2_base[W-1:0])) <<< SHIFT;
    acc_i_d = s2_first ? prod_i : acc_i_q + prod_i;
    acc_q_d = s2_first ? prod_q : acc_q_q + prod_q;
    unique case (s2_op)
      OpPass:   begin comb_i = base_i;          comb_q = base_q;          end
      OpCmul:   begin comb_i = prod_i;          comb_q = prod_q;          end
      OpMulAdd: begin comb_i = base_i + prod_i; comb_q = base_q + prod_q; end
      OpMulSub: begin comb_i = base_i - prod_i; comb_q = base_q - prod_q; end
      OpCmac:   begin comb_i = acc_i_d;         comb_q = acc_q_d;         end
      default:  begin comb_i = prod_i;          comb_q = prod_q;          end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_i_q  <= '0;
      acc_q_q  <= '0;
      s3_valid <= 1'b0;
      s3_i     <= '0;
      s3_q     <= '0;
    end else begin
      if (s2_valid && (s2_op == OpCmac)) begin
        acc_i_q <= acc_i_d;
        acc_q_q <= acc_q_d;
      end
      s3_valid <= s2_valid && ((s2_op != OpCmac) || s2_last);
      s3_i     <= comb_i;
      s3_q     <= comb_q;
    end
  end

  logic signed [W-1:0] rs_i, rs_q;
  logic                clip_i, clip_q;

  cplx_round_sat #(
    .DATA_WIDTH (W),
    .SHIFT      (SHIFT),
    .ACC_WIDTH  (AccW)
  ) u_rs_i (
    .val  (s3_i),
    .res  (rs_i),
    .clip (clip_i)
  );

  cplx_round_sat #(
    .DATA_WIDTH (W),
    .SHIFT      (SHIFT),
    .ACC_WIDTH  (AccW)
  ) u_rs_q (
    .val  (s3_q),
    .res  (rs_q),
    .clip (clip_q)
  );

  logic          out_valid_q, sat_q, sticky_q;
  logic [DW-1:0] dout_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      sat_q       <= 1'b0;
      sticky_q    <= 1'b0;
      dout_q      <= '0;
    end else begin
      out_valid_q <= s3_valid;
      sat_q       <= s3_valid && (clip_i || clip_q);
      dout_q      <= {rs_i, rs_q};
      // A new saturation outranks a coincident clear.
      if (s3_valid && (clip_i || clip_q)) begin
        sticky_q <= 1'b1;
      end else if (bus.sat_clr) begin
        sticky_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.dout       = dout_q;
  assign bus.sat        = sat_q;
  assign bus.sat_sticky = sticky_q;
endmodule

// File: tb/tb_complex_alu_pipe.sv
// Directed and model-checked stimulus for complex_alu_pipe at DATA_WIDTH=16, SHIFT=15.
module tb_complex_alu_pipe;
  import complex_alu_pipe_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  complex_alu_pipe_if #(.DATA_WIDTH(16)) bus ();

  complex_alu_pipe #(
    .DATA_WIDTH (16),
    .SHIFT      (15),
    .ACC_GUARD  (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int n_out = 0;
  logic [32:0] exp_q[$];
  longint acc_i = 0;
  longint acc_q = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every result leaving the pipe is matched in order against the expected queue.
  always @(negedge clk) begin
    if (rst && bus.out_valid) begin
      n_out++;
      if (exp_q.size() == 0) begin
        check_eq("spurious_valid", 64'(bus.out_valid), 64'd0);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        check_eq("dout", 64'(bus.dout), 64'(e[31:0]));
        check_eq("sat", 64'(bus.sat), 64'(e[32]));
      end
    end
  end

  task automatic send(input logic [2:0] op, input logic f, input logic l,
                      input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    bus.in_valid  = 1'b1;
    bus.opcode    = op;
    bus.acc_first = f;
    bus.acc_last  = l;
    bus.din_1     = x;
    bus.din_2     = y;
    bus.din_3     = z;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.in_valid  = 1'b0;
    bus.acc_first = 1'b0;
    bus.acc_last  = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [16:0] rnd_sat(input longint v);
    longint r;
    r = (v + 64'sd16384) >>> 15;
    if (r > 64'sd32767) return {1'b1, 16'h7fff};
    if (r < -64'sd32768) return {1'b1, 16'h8000};
    return {1'b0, r[15:0]};
  endfunction

  // Returns {valid, sat, dout}; tracks the CMAC accumulator with 37-bit wrap.
  function automatic logic [33:0] model(input logic [2:0] op, input logic f, input logic l,
                                        input logic [31:0] x, input logic [31:0] y,
                                        input logic [31:0] z);
    longint xi, xq, yi, yq, zi, zq, pi, pq, vi, vq;
    logic [16:0] ri, rq;
    logic valid;
    xi = longint'($signed(x[31:16])); xq = longint'($signed(x[15:0]));
    yi = longint'($signed(y[31:16])); yq = longint'($signed(y[15:0]));
    zi = longint'($signed(z[31:16])); zq = longint'($signed(z[15:0]));
    pi = xi * yi - xq * yq;
    pq = xq * yi + xi * yq;
    valid = 1'b1;
    vi = pi;
    vq = pq;
    case (op)
      3'b000: begin vi = xi * 32768;      vq = xq * 32768;      end
      3'b100: begin vi = pi;              vq = pq;              end
      3'b101: begin vi = zi * 32768 + pi; vq = zq * 32768 + pq; end
      3'b110: begin vi = zi * 32768 - pi; vq = zq * 32768 - pq; end
      3'b111: begin
        acc_i = f ? pi : acc_i + pi;
        acc_q = f ? pq : acc_q + pq;
        acc_i = (acc_i <<< 27) >>> 27;
        acc_q = (acc_q <<< 27) >>> 27;
        vi = acc_i;
        vq = acc_q;
        valid = l;
      end
      default: valid = 1'b0;
    endcase
    ri = rnd_sat(vi);
    rq = rnd_sat(vq);
    return {valid, ri[16] | rq[16], ri[15:0], rq[15:0]};
  endfunction

  initial begin
    int lat;
    int n0;
    int n_exp;
    logic [33:0] r;
    bus.in_valid = 1'b0; bus.opcode = 3'b000; bus.acc_first = 1'b0; bus.acc_last = 1'b0;
    bus.din_1 = '0; bus.din_2 = '0; bus.din_3 = '0; bus.sat_clr = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check_eq("rst_dout", 64'(bus.dout), 64'd0);
    check_eq("rst_sat", 64'(bus.sat), 64'd0);
    check_eq("rst_sticky", 64'(bus.sat_sticky), 64'd0);
    rst = 1'b1;
    idle(2);

    // CMUL latency and value.
    exp_q.push_back({1'b0, 32'h4000_0000});
    send(OpCmul, 1'b0, 1'b0, 32'h4000_4000, 32'h4000_C000, 32'h0);
    lat = 0;
    for (int k = 2; k <= 8; k++) begin
      idle(1);
      if (bus.out_valid && lat == 0) lat = k;
    end
    check_eq("latency", 64'(lat), 64'(PipeLatency));

    // Saturating CMUL, sticky holds until cleared.
    exp_q.push_back({1'b1, 32'h7FFF_0000});
    send(OpCmul, 1'b0, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h0);
    idle(5);
    check_eq("sticky_set", 64'(bus.sat_sticky), 64'd1);
    idle(3);
    check_eq("sticky_hold", 64'(bus.sat_sticky), 64'd1);
    bus.sat_clr = 1'b1;
    idle(1);
    bus.sat_clr = 1'b0;
    check_eq("sticky_clr", 64'(bus.sat_sticky), 64'd0);

    // sat_clr on the same edge as a saturating result: set wins.
    exp_q.push_back({1'b1, 32'h7FFF_0000});
    send(OpCmul, 1'b0, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h0);
    idle(2);
    bus.sat_clr = 1'b1;
    idle(1);
    bus.sat_clr = 1'b0;
    check_eq("sticky_set_wins", 64'(bus.sat_sticky), 64'd1);
    bus.sat_clr = 1'b1;
    idle(1);
    bus.sat_clr = 1'b0;
    check_eq("sticky_clr2", 64'(bus.sat_sticky), 64'd0);

    // MULADD, MULSUB, an undefined opcode (no output), PASS of extreme values.
    exp_q.push_back({1'b0, 32'h4000_0000});
    exp_q.push_back({1'b0, 32'h0000_0000});
    exp_q.push_back({1'b0, 32'h8000_7FFF});
    send(OpMulAdd, 1'b0, 1'b0, 32'h4000_0000, 32'h4000_0000, 32'h2000_0000);
    send(OpMulSub, 1'b0, 1'b0, 32'h4000_0000, 32'h4000_0000, 32'h2000_0000);
    send(3'b001, 1'b1, 1'b1, 32'h7FFF_7FFF, 32'h7FFF_7FFF, 32'h1111_1111);
    send(OpPass, 1'b0, 1'b0, 32'h8000_7FFF, 32'h8000_8000, 32'h0);
    idle(6);
    check_eq("drain_dir", 64'(exp_q.size()), 64'd0);
    check_eq("sticky_pass", 64'(bus.sat_sticky), 64'd0);

    // CMAC run with a PASS interleaved: PASS emerges first, then the sum.
    n0 = n_out;
    exp_q.push_back({1'b0, 32'h1234_ABCD});
    exp_q.push_back({1'b0, 32'h4000_0000});
    send(OpCmac, 1'b1, 1'b0, 32'h2000_0000, 32'h4000_0000, 32'h0);
    send(OpCmac, 1'b0, 1'b0, 32'h2000_0000, 32'h4000_0000, 32'h0);
    send(OpPass, 1'b0, 1'b0, 32'h1234_ABCD, 32'h7FFF_7FFF, 32'h0);
    send(OpCmac, 1'b0, 1'b0, 32'h2000_0000, 32'h4000_0000, 32'h0);
    send(OpCmac, 1'b0, 1'b1, 32'h2000_0000, 32'h4000_0000, 32'h0);
    idle(6);
    check_eq("cmac_out_count", 64'(n_out - n0), 64'd2);

    // Back-to-back random samples of every opcode against the model.
    n0 = n_out;
    n_exp = 0;
    for (int i = 0; i < 100; i++) begin
      logic [2:0] op;
      logic f, l;
      logic [31:0] x, y, z;
      op = 3'($urandom_range(0, 7));
      f = 1'($urandom_range(0, 1));
      l = 1'($urandom_range(0, 1));
      if (i == 0) begin op = OpCmac; f = 1'b1; end
      x = $urandom; y = $urandom; z = $urandom;
      r = model(op, f, l, x, y, z);
      if (r[33]) begin
        exp_q.push_back(r[32:0]);
        n_exp++;
      end
      send(op, f, l, x, y, z);
    end
    idle(6);
    check_eq("rand_drain", 64'(exp_q.size()), 64'd0);
    check_eq("rand_count", 64'(n_out - n0), 64'(n_exp));

    // Reset with three samples in flight after setting the sticky flag.
    exp_q.push_back({1'b1, 32'h7FFF_0000});
    send(OpCmul, 1'b0, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h0);
    idle(5);
    send(OpCmul, 1'b0, 1'b0, 32'h4000_4000, 32'h4000_C000, 32'h0);
    send(OpCmac, 1'b1, 1'b1, 32'h4000_0000, 32'h4000_0000, 32'h0);
    send(OpMulAdd, 1'b0, 1'b0, 32'h4000_0000, 32'h4000_0000, 32'h2000_0000);
    rst = 1'b0;
    #1;
    check_eq("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    check_eq("mid_rst_dout", 64'(bus.dout), 64'd0);
    check_eq("mid_rst_sat", 64'(bus.sat), 64'd0);
    check_eq("mid_rst_sticky", 64'(bus.sat_sticky), 64'd0);
    idle(2);
    rst = 1'b1;
    n0 = n_out;
    idle(6);
    check_eq("post_rst_quiet", 64'(n_out - n0), 64'd0);
    exp_q.push_back({1'b0, 32'h2000_0000});
    send(OpCmac, 1'b1, 1'b1, 32'h4000_0000, 32'h4000_0000, 32'h0);
    idle(6);
    check_eq("post_rst_drain", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
